// File: rtl/instr_encoder.sv
// RV32I instruction encoder: turns decoded descriptors into packed
// instruction words with sequential byte addresses, one per handshake.
module instr_encoder #(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [2:0]  in_kind,
   input  logic [4:0]  in_rd,
   input  logic [4:0]  in_rs1,
   input  logic [4:0]  in_rs2,
   input  logic [2:0]  in_funct3,
   input  logic        in_funct7b5,
   input  logic [20:0] in_imm,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_instr,
   output logic [31:0] out_addr,
   output logic        err,
   output logic [15:0] count
);

   localparam logic [2:0] K_LW  = 3'd0;
   localparam logic [2:0] K_SW  = 3'd1;
   localparam logic [2:0] K_R   = 3'd2;
   localparam logic [2:0] K_BEQ = 3'd3;
   localparam logic [2:0] K_IA  = 3'd4;
   localparam logic [2:0] K_JAL = 3'd5;

   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_BEQ = 7'b1100011;
   localparam logic [6:0] OP_IA  = 7'b0010011;
   localparam logic [6:0] OP_JAL = 7'b1101111;

   typedef enum logic {S_IDLE, S_HOLD} state_t;

   state_t      r_state;
   logic        r_valid;
   logic [31:0] r_instr;
   logic [31:0] r_addr;
   logic        r_err;
   logic [15:0] r_count;

   logic [31:0] w_enc;
   logic        w_legal;
   logic        w_i_ok;
   logic        w_b_ok;
   logic        w_shift;
   logic [6:0]  w_hi7;
   logic        w_in_xfer;
   logic        w_out_xfer;
   logic        w_load;

   // Range checks: upper bits must be a pure sign extension
   assign w_i_ok  = (&in_imm[20:11]) | ~(|in_imm[20:11]);
   assign w_b_ok  = ((&in_imm[20:12]) | ~(|in_imm[20:12])) & ~in_imm[0];
   assign w_shift = (in_funct3 == 3'b001) || (in_funct3 == 3'b101);

   always_comb begin
      w_enc   = '0;
      w_legal = 1'b0;
      w_hi7   = in_imm[11:5];
      if (w_shift)
         w_hi7 = {1'b0, (in_funct3 == 3'b101) & in_funct7b5, 5'b0};
      case (in_kind)
         K_LW: begin
            w_legal = w_i_ok;
            w_enc   = {in_imm[11:0], in_rs1, 3'b010, in_rd, OP_LW};
         end
         K_SW: begin
            w_legal = w_i_ok;
            w_enc   = {in_imm[11:5], in_rs2, in_rs1, 3'b010,
                       in_imm[4:0], OP_SW};
         end
         K_R: begin
            w_legal = 1'b1;
            w_enc   = {1'b0, in_funct7b5, 5'b0, in_rs2, in_rs1,
                       in_funct3, in_rd, OP_R};
         end
         K_BEQ: begin
            w_legal = w_b_ok;
            w_enc   = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, 3'b000,
                       in_imm[4:1], in_imm[11], OP_BEQ};
         end
         K_IA: begin
            w_legal = w_i_ok;
            w_enc   = {w_hi7, in_imm[4:0], in_rs1, in_funct3, in_rd, OP_IA};
         end
         K_JAL: begin
            w_legal = ~in_imm[0];
            w_enc   = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12],
                       in_rd, OP_JAL};
         end
         default: w_legal = 1'b0;
      endcase
   end

   assign in_ready   = ~r_valid | out_ready;
   assign w_in_xfer  = in_valid & in_ready;
   assign w_out_xfer = r_valid & out_ready;
   assign w_load     = w_in_xfer & w_legal;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_valid <= 1'b0;
         r_instr <= '0;
         r_addr  <= BASE_ADDR;
         r_err   <= 1'b0;
         r_count <= '0;
      end else begin
         if (w_out_xfer) begin
            r_addr  <= r_addr + 32'd4;
            r_count <= r_count + 16'd1;
         end
         if (w_in_xfer && !w_legal)
            r_err <= 1'b1;
         case (r_state)
            S_IDLE: begin
               if (w_load) begin
                  r_instr <= w_enc;
                  r_valid <= 1'b1;
                  r_state <= S_HOLD;
               end
            end
            S_HOLD: begin
               if (w_load) begin
                  r_instr <= w_enc;
               end else if (out_ready) begin
                  r_valid <= 1'b0;
                  r_state <= S_IDLE;
               end
            end
            default: begin
               r_valid <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign out_valid = r_valid;
   assign out_instr = r_instr;
   assign out_addr  = r_addr;
   assign err       = r_err;
   assign count     = r_count;

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: vector table through a scoreboard,
// then hand sequences for back-pressure and mid-operation reset.
module tb_instr_encoder;

   localparam logic [31:0] BASE = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        in_valid, in_ready;
   logic [2:0]  in_kind;
   logic [4:0]  in_rd, in_rs1, in_rs2;
   logic [2:0]  in_funct3;
   logic        in_funct7b5;
   logic [20:0] in_imm;
   logic        out_valid, out_ready;
   logic [31:0] out_instr, out_addr;
   logic        err;
   logic [15:0] count;

   always #5 clk = ~clk;

   instr_encoder #(.BASE_ADDR(BASE)) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_kind(in_kind), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
      .in_funct3(in_funct3), .in_funct7b5(in_funct7b5), .in_imm(in_imm),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_instr(out_instr), .out_addr(out_addr),
      .err(err), .count(count)
   );

   typedef struct {
      logic [2:0]  kind;
      logic [4:0]  rd, rs1, rs2;
      logic [2:0]  f3;
      logic        f7;
      logic [20:0] imm;
      logic        legal;
      logic [31:0] exp;
   } vec_t;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] addr;
      int          cnt;
   } exp_t;

   exp_t sb[$];
   exp_t e;
   vec_t tbl[21];
   int total = 0;
   int bad = 0;
   int n_acc = 0;
   logic [31:0] held;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s act=%h req=%h", name, act, req);
      end
   endtask

   always @(negedge clk) begin
      if (!reset && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_out act=%h req=none", out_instr);
         end else begin
            e = sb.pop_front();
            chk("sb_instr", out_instr, e.instr);
            chk("sb_addr", out_addr, e.addr);
            chk("sb_count", {16'd0, count}, e.cnt);
         end
      end
   end

   function automatic vec_t mk(input logic [2:0] k, input logic [4:0] rd,
                               input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic [2:0] f3, input logic f7,
                               input int imm, input logic lg,
                               input logic [31:0] ex);
      vec_t v;
      v.kind = k; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
      v.f3 = f3; v.f7 = f7; v.imm = imm[20:0];
      v.legal = lg; v.exp = ex;
      return v;
   endfunction

   // Present one descriptor; returns at posedge+1 after its transfer
   task automatic drive(input vec_t v);
      int w;
      in_kind = v.kind; in_rd = v.rd; in_rs1 = v.rs1; in_rs2 = v.rs2;
      in_funct3 = v.f3; in_funct7b5 = v.f7; in_imm = v.imm;
      in_valid = 1'b1;
      w = 0;
      @(negedge clk);
      while (!in_ready && w < 20) begin
         w++;
         @(negedge clk);
      end
      if (!in_ready) begin
         total++;
         bad++;
         $display("FAIL accept_timeout act=0 req=1");
      end else if (v.legal) begin
         sb.push_back('{v.exp, BASE + 32'(4 * n_acc), n_acc});
         n_acc++;
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   initial begin
      in_valid = 0; in_kind = 0; in_rd = 0; in_rs1 = 0; in_rs2 = 0;
      in_funct3 = 0; in_funct7b5 = 0; in_imm = 0; out_ready = 1;

      tbl[0]  = mk(0, 5, 2, 0, 0, 0, 8, 1, 32'h00812283);
      tbl[1]  = mk(2, 3, 1, 2, 0, 0, 0, 1, 32'h002081B3);
      tbl[2]  = mk(2, 3, 1, 2, 0, 1, 0, 1, 32'h402081B3);
      tbl[3]  = mk(1, 31, 2, 6, 0, 0, 12, 1, 32'h00612623);
      tbl[4]  = mk(3, 0, 1, 2, 0, 0, -4, 1, 32'hFE208EE3);
      tbl[5]  = mk(5, 1, 0, 0, 0, 0, 8, 1, 32'h008000EF);
      tbl[6]  = mk(4, 1, 0, 0, 0, 0, -1, 1, 32'hFFF00093);
      tbl[7]  = mk(4, 2, 3, 9, 5, 1, 5, 1, 32'h4051D113);
      tbl[8]  = mk(4, 4, 4, 0, 1, 1, 3, 1, 32'h00321213);
      tbl[9]  = mk(0, 1, 1, 0, 0, 0, 2047, 1, 32'h7FF0A083);
      tbl[10] = mk(1, 0, 0, 0, 0, 0, -2048, 1, 32'h80002023);
      tbl[11] = mk(3, 0, 0, 0, 0, 0, 4094, 1, 32'h7E000FE3);
      tbl[12] = mk(3, 0, 0, 0, 0, 0, -4096, 1, 32'h80000063);
      tbl[13] = mk(5, 0, 0, 0, 0, 0, -2, 1, 32'hFFFFF06F);
      tbl[14] = mk(3, 0, 1, 2, 0, 0, 5, 0, 32'h0);
      tbl[15] = mk(0, 1, 1, 0, 0, 0, 4096, 0, 32'h0);
      tbl[16] = mk(7, 1, 1, 1, 0, 0, 0, 0, 32'h0);
      tbl[17] = mk(1, 0, 0, 0, 0, 0, -2049, 0, 32'h0);
      tbl[18] = mk(5, 1, 0, 0, 0, 0, 3, 0, 32'h0);
      tbl[19] = mk(3, 0, 0, 0, 0, 0, 4096, 0, 32'h0);
      tbl[20] = mk(6, 1, 1, 1, 0, 0, 0, 0, 32'h0);

      #1 reset = 1'b1;
      #1;
      chk("rst_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_instr", out_instr, 32'd0);
      chk("rst_addr", out_addr, BASE);
      chk("rst_err", {31'd0, err}, 32'd0);
      chk("rst_count", {16'd0, count}, 32'd0);
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;

      // Latency: word visible right after the accepting edge
      chk("lat_pre", {31'd0, out_valid}, 32'd0);
      drive(tbl[0]);
      chk("lat_valid", {31'd0, out_valid}, 32'd1);
      chk("lat_instr", out_instr, 32'h00812283);
      @(posedge clk);
      #1;
      chk("lat_drained", {31'd0, out_valid}, 32'd0);

      for (int i = 0; i < 21; i++) begin
         drive(tbl[i]);
         if (tbl[i].legal) begin
            chk($sformatf("err_clear_%0d", i), {31'd0, err}, 32'd0);
         end else begin
            chk($sformatf("err_set_%0d", i), {31'd0, err}, 32'd1);
            chk($sformatf("ill_valid_%0d", i), {31'd0, out_valid}, 32'd0);
            chk($sformatf("ill_count_%0d", i), {16'd0, count}, n_acc);
            chk($sformatf("ill_addr_%0d", i), out_addr,
                BASE + 32'(4 * n_acc));
         end
      end

      // Back-pressure: first word held, second waits, then both move
      out_ready = 1'b0;
      drive(mk(0, 7, 8, 0, 0, 0, 16, 1, 32'h01042383));
      held = out_addr;
      in_kind = 3'd5; in_rd = 5'd2; in_imm = 21'd2048;
      in_valid = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
         chk("bp_valid", {31'd0, out_valid}, 32'd1);
         chk("bp_instr", out_instr, 32'h01042383);
         chk("bp_addr", out_addr, held);
         @(posedge clk);
         #1;
      end
      out_ready = 1'b1;
      @(negedge clk);
      chk("bp_release", {31'd0, in_ready}, 32'd1);
      sb.push_back('{32'h0010016F, BASE + 32'(4 * n_acc), n_acc});
      n_acc++;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      out_ready = 1'b0;
      chk("bp_second_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_second_instr", out_instr, 32'h0010016F);
      chk("bp_second_addr", out_addr, held + 32'd4);

      // Asynchronous reset while a word is held
      #2 reset = 1'b1;
      #1;
      chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
      chk("mid_rst_addr", out_addr, BASE);
      chk("mid_rst_count", {16'd0, count}, 32'd0);
      chk("mid_rst_err", {31'd0, err}, 32'd0);
      sb.delete();
      n_acc = 0;
      @(posedge clk);
      #1 reset = 1'b0;
      out_ready = 1'b1;

      drive(tbl[5]);
      repeat (3) @(posedge clk);
      #1;
      chk("sb_empty", sb.size(), 32'd0);
      chk("final_count", {16'd0, count}, 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Streaming RV32I instruction encoder: the inverse of the single-cycle main decoder. Accepts one decoded instruction descriptor per valid/ready transfer (class, register fields, funct bits, signed immediate) and emits the packed 32-bit instruction word with its byte address, ready to be written into instruction memory. Used by the test/boot loader path to build programs for the core in hardware. Supports exactly the decoder's instruction classes: lw, sw, R-type, beq, I-type ALU, jal.

## Interface
- BASE_ADDR, 32'h0000_0000, address assigned to the first emitted instruction
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high
- in_valid  in  1  descriptor present
- in_ready  out  1  encoder can accept descriptor this cycle
- in_kind  in  3  0=lw, 1=sw, 2=R-type, 3=beq, 4=I-ALU, 5=jal, 6/7=illegal
- in_rd, in_rs1, in_rs2  in  5 each  register indices
- in_funct3  in  3  used for R-type and I-ALU only
- in_funct7b5  in  1  R-type bit 30; I-ALU bit 30 only when funct3=101
- in_imm  in  21  signed immediate (byte offset for sw/beq/jal)
- out_valid  out  1  encoded word held
- out_ready  in  1  consumer accepts word
- out_instr  out  32  encoded instruction
- out_addr  out  32  byte address of out_instr
- err  out  1  sticky: an illegal descriptor was dropped
- count  out  16  instructions emitted (wraps at 2^16)

## Operation
- Opcodes: lw 0000011, sw 0100011, R 0110011, beq 1100011, I-ALU 0010011, jal 1101111.
- Forced funct3: lw/sw 010, beq 000; jal has none.
- Formats: R {funct7b5 at bit30, zeros elsewhere in [31:25], rs2, rs1, f3, rd, op}; I {imm[11:0], rs1, f3, rd, op} (I-ALU shifts, funct3=001/101, override bit30 with funct7b5, bits[31,29:25]=0); S {imm[11:5], rs2, rs1, f3, imm[4:0], op}; B {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op}; J {imm[20], imm[10:1], imm[11], imm[19:12], rd, op}.
- Unused fields (rs2 in I, rd in S/B, etc.) are zero, never copied from input.
- Legality: I/S imm in [-2048, 2047]; B imm in [-4096, 4094] and imm[0]=0; J imm[0]=0 (full 21-bit range); kind 6/7 illegal.
- Illegal descriptor: consumed (handshake completes), no output produced, err set to 1, address and count unchanged.
- Output register: one entry. in_ready = !out_valid | out_ready (combinational pass-through of out_ready).
- Address counter: starts at BASE_ADDR; on each output transfer (out_valid & out_ready), +4, wraps modulo 2^32. count increments on same event.
- State: IDLE (out_valid=0) / HOLD (out_valid=1). IDLE to HOLD on legal input transfer; HOLD to IDLE on output transfer with no legal input same cycle; HOLD stays HOLD on simultaneous output transfer + legal input (new word loaded, address advanced).

## Timing
- Reset values: out_valid=0, out_instr=0, out_addr=BASE_ADDR, err=0, count=0; in_ready=1 after reset.
- Latency: legal descriptor accepted at edge N shows on out_instr/out_valid after edge N; throughput one instruction per cycle with out_ready held high.
- out_instr/out_addr stable while out_valid=1 and out_ready=0.
- err set on edge of the illegal transfer; cleared only by reset.
- Reset asserted mid-operation: held word discarded immediately (out_valid drops asynchronously), address back to BASE_ADDR.

## Test plan
- lw rd=5, rs1=2, imm=8 -> out_instr 0x00812283, out_addr 0x0, out_valid one cycle after accept.
- R-type rd=3, rs1=1, rs2=2, f3=000, funct7b5=0 then 1 back-to-back -> 0x002081B3 at addr 0x0, 0x402081B3 at addr 0x4, count=2.
- sw rs1=2, rs2=6, imm=12, in_rd=31 (must be ignored) -> 0x00612623.
- beq rs1=1, rs2=2, imm=-4 -> 0xFE208EE3; jal rd=1, imm=8 -> 0x008000EF.
- beq imm=5, then lw imm=4096, then kind=7 -> each consumed, no out_valid, err=1, count and out_addr unchanged.
- out_ready low 3 cycles while two descriptors offered -> first word held stable, in_ready=0, second accepted same edge first drains; assert reset while holding -> out_valid=0, out_addr=BASE_ADDR, count=0.
